// File: rtl/uart_frame_serializer_pkg.sv
// Shared debug-print constants: UART geometry, frame tags and the serializer state encoding.
package uart_frame_serializer_pkg;

    localparam int unsigned UART_BUS_SIZE = 8;
    localparam int unsigned FRAME_BYTES   = 7;

    localparam logic [7:0] TagReg = 8'h01;
    localparam logic [7:0] TagMem = 8'h02;
    localparam logic [7:0] TagPc  = 8'h03;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWaitDone,
        StFinish
    } state_e;

endpackage

// File: rtl/tx_watchdog.sv
// Saturating per-byte timeout counter; expired_o flags the wait cycle in which the count
// reaches TIMEOUT_CYCLES-1, so the caller can abort on that same edge.
module tx_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntArm = CntW'(TIMEOUT_CYCLES - 2);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Armed one below the limit: this enabled cycle is the one that takes the count to the limit.
    assign expired_o = enable_i && (cnt_q >= CntArm);

endmodule

// File: rtl/uart_frame_serializer.sv
// Sends one debug frame as FRAME_BYTES UART bytes, MSB first, handshaking each byte with
// i_tx_done and aborting with a sticky error if the transmitter stalls.
module uart_frame_serializer #(
    parameter int unsigned UART_BUS_SIZE    = uart_frame_serializer_pkg::UART_BUS_SIZE,
    parameter int unsigned FRAME_BYTES      = uart_frame_serializer_pkg::FRAME_BYTES,
    parameter int unsigned DATA_IN_BUS_SIZE = UART_BUS_SIZE * FRAME_BYTES,
    parameter int unsigned TIMEOUT_CYCLES   = 1000000
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_write,
    input  logic [DATA_IN_BUS_SIZE-1:0] i_data,
    input  logic                        i_tx_done,
    output logic                        o_tx_start,
    output logic [UART_BUS_SIZE-1:0]    o_tx_data,
    output logic                        o_write_finish,
    output logic                        o_busy,
    output logic                        o_error
);

    import uart_frame_serializer_pkg::*;

    localparam int unsigned CntW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [CntW-1:0] LastByte = CntW'(FRAME_BYTES - 1);

    state_e                      state_q, state_d;
    logic [DATA_IN_BUS_SIZE-1:0] shift_q, shift_d;
    logic [CntW-1:0]             byte_cnt_q, byte_cnt_d;
    logic                        error_q, error_d;
    logic                        wd_clear, wd_enable, wd_expired;

    tx_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tx_watchdog (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .clear_i  (wd_clear),
        .enable_i (wd_enable),
        .expired_o(wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        error_d    = error_q;
        wd_clear   = 1'b0;
        wd_enable  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_write) begin
                    shift_d    = i_data;
                    byte_cnt_d = '0;
                    error_d    = 1'b0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                wd_clear = 1'b1;
                state_d  = StWaitDone;
            end
            StWaitDone: begin
                // A done pulse beats a simultaneous expiry.
                if (i_tx_done) begin
                    shift_d    = shift_q << UART_BUS_SIZE;
                    byte_cnt_d = byte_cnt_q + CntW'(1);
                    state_d    = (byte_cnt_q == LastByte) ? StFinish : StSend;
                end else begin
                    wd_enable = 1'b1;
                    if (wd_expired) begin
                        error_d = 1'b1;
                        state_d = StFinish;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            error_q    <= error_d;
        end
    end

    assign o_tx_start     = (state_q == StSend);
    assign o_tx_data      = shift_q[DATA_IN_BUS_SIZE-1 -: UART_BUS_SIZE];
    assign o_write_finish = (state_q == StFinish);
    assign o_busy         = (state_q != StIdle);
    assign o_error        = error_q;

endmodule

// File: tb/tb_uart_frame_serializer.sv
// Self-checking bench: table-driven and random frames against a per-byte timing model,
// plus reset and spurious-done sequences.
module tb_uart_frame_serializer;

    localparam int unsigned T  = 16;
    localparam int unsigned NB = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr  = 1'b0;
    logic        txd = 1'b0;
    logic [55:0] data = '0;
    logic        o_tx_start, o_write_finish, o_busy, o_error;
    logic [7:0]  o_tx_data;

    int checks = 0;
    int errors = 0;
    int dly[NB];

    typedef struct {
        logic [55:0] data;
        int          wlen;
        int          delay;
        int          abort_idx;
        int          abort_dly;
        int          rst_after;
        int          exp_starts;
        bit          exp_err;
    } vec_t;

    uart_frame_serializer #(
        .UART_BUS_SIZE   (8),
        .FRAME_BYTES     (NB),
        .DATA_IN_BUS_SIZE(56),
        .TIMEOUT_CYCLES  (T)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_write       (wr),
        .i_data        (data),
        .i_tx_done     (txd),
        .o_tx_start    (o_tx_start),
        .o_tx_data     (o_tx_data),
        .o_write_finish(o_write_finish),
        .o_busy        (o_busy),
        .o_error       (o_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] expb(input logic [55:0] d, input int k);
        logic [55:0] s;
        s = d >> (8 * (NB - 1 - k));
        return s[7:0];
    endfunction

    // Byte k starts one cycle after the previous byte's done; a byte whose done would come
    // T or more cycles after its start is aborted, with FINISH exactly T cycles after start.
    function automatic void model(output int starts, output bit err, output int fin);
        int t;
        t      = 1;
        starts = NB;
        err    = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (dly[k] >= int'(T)) begin
                starts = k + 1;
                err    = 1'b1;
                fin    = t + int'(T);
                return;
            end
            t += 1 + dly[k];
        end
        fin = t;
    endfunction

    task automatic run_frame(input logic [55:0] d, input int wlen, input int rst_after,
                             input int exp_starts, input bit exp_err, input string tag);
        int cyc, nstart, ndone, since, nfin, m_starts, m_fin;
        bit m_err, waiting, fin, rst_pend, rst_phase, busy_ok, stable_ok;
        cyc = 0; nstart = 0; ndone = 0; since = 0; nfin = 0;
        waiting = 0; fin = 0; rst_pend = 0; rst_phase = 0; busy_ok = 1; stable_ok = 1;
        model(m_starts, m_err, m_fin);
        @(negedge clk);
        data = d;
        wr   = 1'b1;
        while (!fin && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (cyc >= wlen) wr = 1'b0;
            txd = 1'b0;
            if (rst_phase) begin
                chk({tag, " reset outputs"},
                    {o_tx_start, o_write_finish, o_busy, o_error, o_tx_data}, 64'd0);
                chk({tag, " no finish on reset"}, nfin, 0);
                rst = 1'b0;
                fin = 1;
            end else begin
                if (rst_pend) begin
                    rst       = 1'b1;
                    rst_phase = 1;
                end
                if (o_tx_start) begin
                    if (nstart < int'(NB))
                        chk($sformatf("%s byte%0d", tag, nstart), o_tx_data, expb(d, nstart));
                    if (nstart == 0) chk({tag, " error cleared"}, o_error, 1'b0);
                    nstart++;
                    since   = 0;
                    waiting = 1;
                end else if (waiting) begin
                    since++;
                    if (nstart <= int'(NB) && o_tx_data !== expb(d, nstart - 1)) stable_ok = 0;
                end
                if (o_write_finish) begin
                    nfin++;
                    if (rst_after == 0) begin
                        fin = 1;
                        chk({tag, " starts"}, nstart, exp_starts);
                        chk({tag, " error"}, o_error, exp_err);
                        chk({tag, " finish cycle"}, cyc, m_fin);
                    end
                end else if (!o_busy) begin
                    busy_ok = 0;
                end
                if (!fin && !rst_pend && waiting && nstart <= int'(NB) && since == dly[nstart-1]) begin
                    txd     = 1'b1;
                    waiting = 0;
                    ndone++;
                    if (rst_after > 0 && ndone == rst_after) rst_pend = 1;
                end
            end
        end
        wr  = 1'b0;
        txd = 1'b0;
        rst = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL %s budget: got no end of frame after %0d cycles, required one", tag, cyc);
        end
        chk({tag, " busy held"}, busy_ok, 1'b1);
        chk({tag, " data stable"}, stable_ok, 1'b1);
        @(negedge clk);
        chk({tag, " idle after"}, {o_write_finish, o_busy, o_tx_start}, 64'd0);
    endtask

    initial begin
        vec_t tbl[8];
        int   r_starts, r_fin;
        bit   r_err;
        logic [55:0] rd;

        tbl[0] = '{56'h03_07_00_00000040, 1, 3, -1, 0, 0, 7, 1'b0};
        tbl[1] = '{56'h01_05_03_DEADBEEF, 1, 10, -1, 0, 0, 7, 1'b0};
        tbl[2] = '{56'h02_11_22_33445566, 3, 2, -1, 0, 0, 7, 1'b0};
        tbl[3] = '{56'h01_A5_5A_0F0FF0F0, 1, 5, 1, 40, 0, 2, 1'b1};
        tbl[4] = '{56'h02_80_01_7FFFFFFF, 2, 4, -1, 0, 0, 7, 1'b0};
        tbl[5] = '{56'h03_FF_FE_12345678, 1, 15, -1, 0, 0, 7, 1'b0};
        tbl[6] = '{56'h01_00_00_00000000, 1, 1, 0, 16, 0, 1, 1'b1};
        tbl[7] = '{56'h02_C3_3C_CAFEF00D, 1, 6, -1, 0, 4, 0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset outputs", {o_tx_start, o_write_finish, o_busy, o_error, o_tx_data}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle not busy", o_busy, 1'b0);

        // Stray done pulses while idle must not consume a byte of the next frame.
        txd = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("spurious done idle", {o_busy, o_tx_start}, 64'd0);
        end
        txd = 1'b0;

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < int'(NB); k++) dly[k] = tbl[i].delay;
            if (tbl[i].abort_idx >= 0) dly[tbl[i].abort_idx] = tbl[i].abort_dly;
            run_frame(tbl[i].data, tbl[i].wlen, tbl[i].rst_after, tbl[i].exp_starts,
                      tbl[i].exp_err, $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 25; n++) begin
            rd        = {$urandom, $urandom};
            rd[55:48] = 8'($urandom_range(1, 3));
            for (int k = 0; k < int'(NB); k++) dly[k] = $urandom_range(1, 15);
            if ($urandom_range(0, 4) == 0) dly[$urandom_range(0, NB - 1)] = $urandom_range(15, 18);
            model(r_starts, r_err, r_fin);
            run_frame(rd, $urandom_range(1, 4), 0, r_starts, r_err, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
